rtmq_uart_tx_arb: RTL
=====================

RTMQ_UART_TX_ARB -- requirements
Module: rtmq_uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of frame requesters, 2..8.
REQ-002 Parameter W_DAT, default W_REG: frame width in bits, a multiple of 8.
REQ-003 Parameter T_TOT, default 65535: WAIT-state timeout in clk cycles, 16-bit.
REQ-004 Parameter N_GAP, default 1: idle cycles after each frame, 1..15.
REQ-005 clk  in  1: system clock; the block has one clock.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 req  in  N_REQ: per-requester frame-pending flags, level.
REQ-008 dat  in  N_REQ*W_DAT: per-requester frames; requester i owns bits [i*W_DAT +: W_DAT].
REQ-009 gnt  out  N_REQ: one-cycle pulse, one-hot, marking frame accepted.
REQ-010 tx_dat  out  W_DAT: frame to the UART transmitter.
REQ-011 tx_snd  out  1: one-cycle send strobe to the UART transmitter.
REQ-012 tx_fin  in  1: transmitter finish flag.
REQ-013 busy  out  1: high in any state other than IDLE.
REQ-014 err_tot  out  1: one-cycle pulse on a timeout.
REQ-015 gnt_id  out  clog2(N_REQ): index of the last granted requester.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and GAP.
REQ-017 In IDLE with any req bit set, the block SHALL pick winner i by round-robin, searching from ptr+1 modulo N_REQ, then enter ISSUE on the next cycle.
REQ-018 On entry to ISSUE, in the same cycle:
  - tx_dat SHALL equal the winner's frame, captured at selection;
  - tx_snd=1 and gnt[i]=1 SHALL each assert for exactly one cycle;
  - ptr and gnt_id SHALL be set to i.
REQ-019 Latency from req sampled in IDLE to tx_snd SHALL be exactly 1 cycle.
REQ-020 ISSUE SHALL last one cycle, then go to WAIT with the timeout counter cleared.
REQ-021 Requesters hold req and dat until gnt; a req dropped before gnt is withdrawn with no side effect.
REQ-022 Changes to req or dat after selection SHALL NOT alter tx_dat.
REQ-023 In WAIT, tx_fin=1 SHALL move the FSM to GAP.
REQ-024 In WAIT, when the counter reaches T_TOT-1 without tx_fin, the block SHALL pulse err_tot for one cycle and move to GAP.
REQ-025 If tx_fin and the timeout occur in the same cycle, tx_fin SHALL win and err_tot SHALL stay 0.
REQ-026 GAP SHALL last exactly N_GAP cycles, then return to IDLE.
REQ-027 req SHALL be ignored in every state except IDLE.
REQ-028 tx_fin SHALL be ignored in IDLE, ISSUE and GAP.
REQ-029 tx_dat SHALL hold its last value until the next ISSUE.
REQ-030 A requester that holds req continuously SHALL be granted within N_REQ frames (no starvation).
REQ-031 Back-to-back frames SHALL have a minimum tx_snd spacing of 3+N_GAP cycles plus the transmitter's frame time.

Reset
REQ-032 rst SHALL be sampled only on the clk rising edge and SHALL override all other inputs.
REQ-033 On reset: state=IDLE, gnt=0, tx_snd=0, err_tot=0, busy=0, tx_dat=0, gnt_id=0, counters=0.
REQ-034 On reset, ptr SHALL be N_REQ-1, so requester 0 has first priority.
REQ-035 Reset asserted mid-WAIT SHALL abort the frame with no err_tot and no gnt.
REQ-036 A tx_fin that arrives after reset SHALL be ignored.

Structure
REQ-037 State encodings and the default T_TOT/N_GAP constants SHALL live in the shared peripheral package.
REQ-038 One sub-module, rtmq_rr_pick, SHALL contain the round-robin selector; it is combinational.
REQ-039 The FSM, the capture register and the counters SHALL live in the top module.

Verification
REQ-040 Single request: req=4'b0100, dat[2]=32'hDEADBEEF -> next cycle tx_snd=1, gnt=4'b0100, tx_dat=32'hDEADBEEF; tx_fin at cycle 20 -> busy low N_GAP cycles later.
REQ-041 Fairness: req=4'b1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-042 Timeout: T_TOT=100, tx_fin never arrives -> err_tot pulses 100 cycles after ISSUE, then GAP, then IDLE.
REQ-043 Collision: tx_fin and the timeout fall in the same cycle -> err_tot=0 and the FSM goes to GAP.
REQ-044 Reset mid-WAIT, then a late tx_fin -> state IDLE, all outputs 0, the next grant goes to requester 0.

Source files
------------

// File: rtl/rtmq_uart_tx_arb_pkg.sv
// Shared constants and state encoding for the RTMQ UART transmit arbiter.
package rtmq_uart_tx_arb_pkg;

  localparam int unsigned W_REG     = 32;
  localparam int unsigned T_TOT_DEF = 65535;
  localparam int unsigned N_GAP_DEF = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StGap   = 2'd3
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtmq_uart_tx_arb_if.sv
// Requester and UART-transmitter signals of the arbiter, bundled as one interface.
interface rtmq_uart_tx_arb_if
  import rtmq_uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_DAT = W_REG
);
  localparam int unsigned W_IDX = idx_width(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*W_DAT-1:0] dat;
  logic [N_REQ-1:0]       gnt;
  logic [W_DAT-1:0]       tx_dat;
  logic                   tx_snd;
  logic                   tx_fin;
  logic                   busy;
  logic                   err_tot;
  logic [W_IDX-1:0]       gnt_id;

  modport master (
    output req, dat, tx_fin,
    input  gnt, tx_dat, tx_snd, busy, err_tot, gnt_id
  );

  modport slave (
    input  req, dat, tx_fin,
    output gnt, tx_dat, tx_snd, busy, err_tot, gnt_id
  );

endinterface

// File: rtl/rtmq_uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first set req bit after ptr, wrapping modulo N_REQ.
module rtmq_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_IDX = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W_IDX-1:0] ptr,
  output logic             vld,
  output logic [W_IDX-1:0] idx
);

  always_comb begin
    int j;
    j   = 0;
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      j = (int'(ptr) + k) % int'(N_REQ);
      if (!vld && req[j[W_IDX-1:0]]) begin
        vld = 1'b1;
        idx = j[W_IDX-1:0];
      end
    end
  end

endmodule

// File: rtl/rtmq_uart_tx_arb.sv
// Round-robin arbiter feeding frames from N_REQ requesters into one UART transmitter,
// with a transmit-finish timeout and a fixed inter-frame gap.
module rtmq_uart_tx_arb
  import rtmq_uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_DAT = W_REG,
  parameter int unsigned T_TOT = T_TOT_DEF,
  parameter int unsigned N_GAP = N_GAP_DEF
) (
  input logic               clk,
  input logic               rst,
  rtmq_uart_tx_arb_if.slave bus
);

  localparam int unsigned W_IDX    = idx_width(N_REQ);
  localparam logic [15:0] TOT_LAST = 16'(T_TOT - 1);
  localparam logic [3:0]  GAP_LAST = 4'(N_GAP - 1);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [W_DAT-1:0] tx_dat_q;
  logic             tx_snd_q;
  logic             busy_q;
  logic             err_tot_q;
  logic [W_IDX-1:0] gnt_id_q;
  logic [W_IDX-1:0] ptr_q;
  logic [15:0]      tot_cnt_q;
  logic [3:0]       gap_cnt_q;

  logic             pick_vld;
  logic [W_IDX-1:0] pick_idx;
  logic [15:0]      tot_nxt;

  rtmq_rr_pick #(
    .N_REQ (N_REQ),
    .W_IDX (W_IDX)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign tot_nxt = tot_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      tx_dat_q  <= '0;
      tx_snd_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_tot_q <= 1'b0;
      gnt_id_q  <= '0;
      ptr_q     <= W_IDX'(N_REQ - 1);
      tot_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      // Strobes default low so every assertion lasts exactly one cycle.
      gnt_q     <= '0;
      tx_snd_q  <= 1'b0;
      err_tot_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            state_q  <= StIssue;
            busy_q   <= 1'b1;
            tx_snd_q <= 1'b1;
            gnt_q    <= N_REQ'(1) << pick_idx;
            tx_dat_q <= bus.dat[int'(pick_idx)*W_DAT +: W_DAT];
            ptr_q    <= pick_idx;
            gnt_id_q <= pick_idx;
          end
        end
        StIssue: begin
          state_q   <= StWait;
          tot_cnt_q <= '0;
        end
        StWait: begin
          // A finish in the timeout cycle takes precedence over the error.
          if (bus.tx_fin) begin
            state_q   <= StGap;
            gap_cnt_q <= '0;
          end else if (tot_nxt == TOT_LAST) begin
            state_q   <= StGap;
            gap_cnt_q <= '0;
            err_tot_q <= 1'b1;
          end else begin
            tot_cnt_q <= tot_nxt;
          end
        end
        StGap: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.tx_dat  = tx_dat_q;
  assign bus.tx_snd  = tx_snd_q;
  assign bus.busy    = busy_q;
  assign bus.err_tot = err_tot_q;
  assign bus.gnt_id  = gnt_id_q;

endmodule
